// File: rtl/obi_lsu_initiator.sv
// obi_lsu_initiator
//   Load/store initiator for a req/gnt/rvalid memory data port. Takes byte, half
//   and word commands from a valid/ready source and issues word-aligned bus
//   requests with byte enables and lane-replicated write data. Up to
//   MAX_OUTSTANDING granted transactions are tracked in a small FIFO. Responses
//   come back in order, and load data is lane-extracted and sign/zero-extended.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o command handshake; addr/we/size/unsigned/wdata qualify it
//   data_req_o/gnt_i   bus address phase; addr/we/be/wdata qualify the request
//   data_rvalid_i/rdata_i bus response phase, one per grant, in order
//   rsp_valid_o        one-cycle response pulse with rsp_we_o and rsp_rdata_o
//   busy_o             a request is pending or a granted transaction awaits rvalid
//
// Handshakes: a command transfers on a rising edge where cmd_valid_i && cmd_ready_o.
// A bus request transfers on a rising edge where data_req_o && data_gnt_i. Until then
// the request and all its qualifiers stay stable. rsp_valid_o is not backpressured.

module obi_lsu_initiator #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic                  cmd_we_i,
  input  logic [1:0]            cmd_size_i,
  input  logic                  cmd_unsigned_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_we_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] MAX_OCC  = OW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  // Per-transaction info needed to shape the response once rvalid arrives.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } track_t;

  // Request register
  logic                  run_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [1:0]            off_q;

  // Tracking FIFO
  track_t                fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  track_t                head;

  // Response register
  logic                  rsp_valid_q;
  logic                  rsp_we_q;
  logic [31:0]           rsp_rdata_q;

  // Command decode
  logic [1:0]            cmd_size_n;
  logic [1:0]            cmd_off;
  logic [3:0]            cmd_be;
  logic [31:0]           cmd_wdata;
  logic                  cmd_accept;
  logic                  push, pop;
  logic [OW-1:0]         occupancy;
  logic [31:0]           lane;
  logic [31:0]           ext;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Size 11 is handled as a word. Offset bits below the access size are dropped,
  // so an access never straddles a word.
  always_comb begin
    cmd_size_n = (cmd_size_i == 2'b11) ? 2'b10 : cmd_size_i;
    cmd_off    = 2'b00;
    cmd_be     = 4'b1111;
    cmd_wdata  = cmd_wdata_i;
    case (cmd_size_n)
      2'b00: begin
        cmd_off   = cmd_addr_i[1:0];
        cmd_be    = 4'b0001 << cmd_addr_i[1:0];
        cmd_wdata = {4{cmd_wdata_i[7:0]}};
      end
      2'b01: begin
        cmd_off   = {cmd_addr_i[1], 1'b0};
        cmd_be    = 4'b0011 << {cmd_addr_i[1], 1'b0};
        cmd_wdata = {2{cmd_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // A pending request already owns a FIFO slot, so it counts toward occupancy.
  // run_q keeps cmd_ready_o low while in reset and for the first cycle after.
  assign occupancy   = OW'(count_q) + OW'(req_q);
  assign cmd_ready_o = run_q && (!req_q || data_gnt_i) && (occupancy < MAX_OCC);
  assign cmd_accept  = cmd_valid_i && cmd_ready_o;
  assign push        = req_q && data_gnt_i;
  assign pop         = data_rvalid_i && (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (cmd_accept) begin
        req_q   <= 1'b1;
        addr_q  <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
        we_q    <= cmd_we_i;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
        size_q  <= cmd_size_n;
        uns_q   <= cmd_unsigned_i;
        off_q   <= cmd_off;
      end else if (data_gnt_i) begin
        req_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= '{we: we_q, size: size_q, uns: uns_q, off: off_q};
  end

  assign head = fifo_q[rptr_q];

  always_comb begin
    lane = data_rdata_i >> {head.off, 3'b000};
    ext  = lane;
    case (head.size)
      2'b00:   ext = {{24{!head.uns && lane[7]}}, lane[7:0]};
      2'b01:   ext = {{16{!head.uns && lane[15]}}, lane[15:0]};
      default: ;
    endcase
    if (head.we) ext = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= pop;
      if (pop) begin
        rsp_we_q    <= head.we;
        rsp_rdata_q <= ext;
      end
    end
  end

  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_we_o     = rsp_we_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = req_q || (count_q != '0);

endmodule

// File: tb/tb_obi_lsu_initiator.sv
// tb_obi_lsu_initiator
//   Bench for obi_lsu_initiator. A memory slave model answers the bus with random
//   grants and response delays. A byte-addressed reference memory predicts the bus
//   request and the response of every command.

module tb_obi_lsu_initiator;

  localparam int MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_we = 1'b0;
  logic [1:0]  cmd_size = '0;
  logic        cmd_uns = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        rsp_valid;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        busy;

  obi_lsu_initiator #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_we_i(cmd_we), .cmd_size_i(cmd_size), .cmd_unsigned_i(cmd_uns),
    .cmd_wdata_i(cmd_wdata),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
    .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [32:0] exp_q[$];    // {we, rdata}
  logic [68:0] bus_q[$];    // {addr, we, be, wdata}
  logic [63:0] slave_q[$];  // {rdata, due_cycle}
  logic [7:0]  ref_mem [256];
  logic [31:0] slave_mem [64];
  int          tracked = 0;
  logic        rsp_due = 1'b0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          req_len = 0;
  int          last_req_len = 0;
  logic [31:0] last_g_addr = '0, last_g_wdata = '0;
  logic [3:0]  last_g_be = '0;
  logic [31:0] last_rsp_rdata = '0;
  logic        last_rsp_we = 1'b0;

  // slave controls
  int gnt_prob = 100;
  int dly_min = 1, dly_max = 1;
  int hold_target = 0, hold_used = 0;
  int stray_target = 0, stray_used = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: what a command must put on the bus and what it must return.
  task automatic model_cmd(input logic [31:0] a, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd);
    int unsigned n, eff, lane;
    logic [31:0] be, wrep, v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    eff  = a & ~(n - 1);
    lane = eff % 4;
    be   = ((32'd1 << n) - 1) << lane;
    wrep = '0;
    for (int i = 0; i < 4; i++) wrep = wrep | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    bus_q.push_back({eff - lane, we, be[3:0], wrep});
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[eff + i] = 8'((wd >> (8 * i)) & 32'hFF);
      exp_q.push_back({1'b1, 32'd0});
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_mem[eff + i]) << (8 * i));
      if (!uns && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
      exp_q.push_back({1'b0, v});
    end
  endtask

  // ---------------- memory slave (drives on falling edge) ----------------
  initial begin
    forever begin
      @(negedge clk);
      data_gnt = ($urandom_range(99, 0) < gnt_prob);
      if (hold_used < hold_target && data_req) begin
        data_gnt = 1'b0;
        hold_used++;
      end
      data_rvalid = 1'b0;
      data_rdata  = $urandom;
      if (stray_used < stray_target) begin
        data_rvalid = 1'b1;
        stray_used++;
      end else if (slave_q.size() > 0 && int'(slave_q[0][31:0]) <= cyc) begin
        data_rvalid = 1'b1;
        data_rdata  = slave_q[0][63:32];
      end
    end
  end

  // ---------------- monitor / scoreboard (samples 1 ns before rising edge) ----------------
  initial begin
    logic        prev_stall;
    logic [31:0] st_addr, st_wdata;
    logic [3:0]  st_be;
    logic        st_we, due_next;
    logic [68:0] b;
    logic [32:0] e;
    logic [31:0] rd;
    int          idx;
    prev_stall = 1'b0;
    st_addr = '0; st_wdata = '0; st_be = '0; st_we = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 64; w++)
      slave_mem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    forever begin
      @(negedge clk);
      #4;
      if (!rst_ni) begin
        check("rst_ctrl_outs", 32'({data_req, cmd_ready, rsp_valid, busy, data_we, rsp_we}), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_be", 32'(data_be), 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        exp_q.delete(); bus_q.delete(); slave_q.delete();
        tracked = 0; rsp_due = 1'b0; prev_stall = 1'b0; req_len = 0;
      end else begin
        if (prev_stall) begin
          check("hold_req", 32'(data_req), 32'd1);
          check("hold_addr", data_addr, st_addr);
          check("hold_we", 32'(data_we), 32'(st_we));
          check("hold_be", 32'(data_be), 32'(st_be));
          check("hold_wdata", data_wdata, st_wdata);
        end
        if (data_req && !data_gnt) check("stall_ready", 32'(cmd_ready), 32'd0);
        check("occupancy", 32'(tracked + int'(data_req) <= MAX_OUT), 32'd1);
        check("busy", 32'(busy), 32'(data_req || tracked > 0));
        check("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
        if (rsp_valid) begin
          rsp_cnt++;
          if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("rsp_we", 32'(rsp_we), 32'(e[32]));
            check("rsp_rdata", rsp_rdata, e[31:0]);
            last_rsp_we = rsp_we;
            last_rsp_rdata = rsp_rdata;
          end
        end
        // events of this cycle
        due_next = 1'b0;
        if (data_rvalid) begin
          if (tracked > 0) begin
            tracked--;
            due_next = 1'b1;
          end
          if (slave_q.size() > 0 && stray_used >= stray_target) void'(slave_q.pop_front());
        end
        if (data_req) req_len++;
        if (data_req && data_gnt) begin
          if (bus_q.size() == 0) check("grant_unexpected", 32'd1, 32'd0);
          else begin
            b = bus_q.pop_front();
            check("bus_addr", data_addr, b[68:37]);
            check("bus_we", 32'(data_we), 32'(b[36]));
            check("bus_be", 32'(data_be), 32'(b[35:32]));
            check("bus_wdata", data_wdata, b[31:0]);
          end
          idx = int'(data_addr[7:2]);
          if (data_we) begin
            for (int l = 0; l < 4; l++)
              if (data_be[l]) slave_mem[idx][8*l +: 8] = data_wdata[8*l +: 8];
            rd = $urandom;
          end else begin
            rd = slave_mem[idx];
          end
          slave_q.push_back({rd, 32'(cyc + $urandom_range(dly_max, dly_min))});
          tracked++;
          last_req_len = req_len;
          req_len = 0;
          last_g_addr = data_addr; last_g_be = data_be; last_g_wdata = data_wdata;
        end
        if (cmd_valid && cmd_ready) begin
          model_cmd(cmd_addr, cmd_we, cmd_size, cmd_uns, cmd_wdata);
          acc_cnt++;
        end
        prev_stall = data_req && !data_gnt;
        st_addr = data_addr; st_we = data_we; st_be = data_be; st_wdata = data_wdata;
        rsp_due = due_next;
      end
      cyc++;
    end
  end

  // ---------------- driver tasks (called at falling edge) ----------------
  task automatic send_cmd(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd);
    int base;
    base = acc_cnt;
    cmd_valid = 1'b1; cmd_addr = a; cmd_we = we; cmd_size = sz; cmd_uns = uns; cmd_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt != base) return;
    end
    check("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic cmd_idle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!data_req && tracked == 0 && !rsp_due && exp_q.size() == 0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mark;
    repeat (3) @(negedge clk);
    #1 rst_ni = 1'b1;

    // Store word, immediate grant, 1-cycle response
    gnt_prob = 100; dly_min = 1; dly_max = 1;
    send_cmd(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF); cmd_idle();
    wait_idle();
    check("sw_req_len", 32'(last_req_len), 32'd1);
    check("sw_addr", last_g_addr, 32'h10);
    check("sw_be", 32'(last_g_be), 32'hF);
    check("sw_rsp_we", 32'(last_rsp_we), 32'd1);
    check("sw_rsp_rdata", last_rsp_rdata, 32'd0);

    // Byte loads from word 0x80FF0000 at byte 0x13
    send_cmd(32'h10, 1'b1, 2'd2, 1'b0, 32'h80FF0000);
    send_cmd(32'h13, 1'b0, 2'd0, 1'b0, 32'h0); cmd_idle();
    wait_idle();
    check("lb_be", 32'(last_g_be), 32'h8);
    check("lb_signed", last_rsp_rdata, 32'hFFFFFF80);
    send_cmd(32'h13, 1'b0, 2'd0, 1'b1, 32'h0); cmd_idle();
    wait_idle();
    check("lbu_unsigned", last_rsp_rdata, 32'h00000080);

    // Half store at 0x16, misaligned word store at 0x17
    send_cmd(32'h16, 1'b1, 2'd1, 1'b0, 32'h1234ABCD); cmd_idle();
    wait_idle();
    check("sh_addr", last_g_addr, 32'h14);
    check("sh_be", 32'(last_g_be), 32'hC);
    check("sh_wdata", last_g_wdata, 32'hABCDABCD);
    send_cmd(32'h17, 1'b1, 2'd3, 1'b0, 32'h11223344); cmd_idle();
    wait_idle();
    check("sw17_addr", last_g_addr, 32'h14);
    check("sw17_be", 32'(last_g_be), 32'hF);

    // Grant withheld for 3 cycles while a second command waits
    hold_target = hold_target + 3;
    send_cmd(32'h40, 1'b1, 2'd0, 1'b0, 32'h000000A5);
    send_cmd(32'h44, 1'b0, 2'd2, 1'b0, 32'h0); cmd_idle();
    check("stall_req_len", 32'(last_req_len), 32'd4);
    wait_idle();

    // Three back-to-back loads, 4-cycle response delay
    dly_min = 4; dly_max = 4;
    mark = rsp_cnt;
    send_cmd(32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    send_cmd(32'h14, 1'b0, 2'd1, 1'b0, 32'h0);
    send_cmd(32'h17, 1'b0, 2'd0, 1'b1, 32'h0); cmd_idle();
    check("third_after_first_rsp", 32'(rsp_cnt - mark), 32'd1);
    wait_idle();

    // Reset with two loads outstanding, then stray responses
    dly_min = 30; dly_max = 30;
    send_cmd(32'h20, 1'b0, 2'd2, 1'b0, 32'h0);
    send_cmd(32'h24, 1'b0, 2'd1, 1'b0, 32'h0); cmd_idle();
    for (int i = 0; i < 20 && tracked < 2; i++) @(negedge clk);
    check("two_outstanding", 32'(tracked), 32'd2);
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_ni = 1'b1;
    mark = rsp_cnt;
    stray_target = stray_target + 2;
    repeat (6) @(negedge clk);
    check("stray_no_rsp", 32'(rsp_cnt - mark), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_req", 32'(data_req), 32'd0);

    // Randomized traffic
    gnt_prob = 70; dly_min = 1; dly_max = 5;
    for (int n = 0; n < 250; n++) begin
      send_cmd(32'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
               1'($urandom_range(1, 0)), $urandom);
      if ($urandom_range(3, 0) == 0) begin
        cmd_idle();
        repeat ($urandom_range(2, 1)) @(negedge clk);
      end
    end
    cmd_idle();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
